// File: rtl/definitions_pkg.sv
// Shared definitions for the sliding-window line buffer.
//   wbuf_state_t    : FILL while the first K-1 rows are loaded, STREAM once windows can be emitted
//   WBUF_DEF_WIDTH  : default largest frame width (line-buffer depth)
//   WBUF_DEF_HEIGHT : default largest frame height
//   wbuf_clamp()    : saturate a runtime frame dimension into [lo, hi]
package definitions_pkg;

    typedef enum logic {
        FILL   = 1'b0,
        STREAM = 1'b1
    } wbuf_state_t;

    localparam int unsigned WBUF_DEF_WIDTH  = 640;
    localparam int unsigned WBUF_DEF_HEIGHT = 480;

    function automatic int unsigned wbuf_clamp(input int unsigned val,
                                               input int unsigned lo,
                                               input int unsigned hi);
        if (val < lo) begin
            return lo;
        end
        if (val > hi) begin
            return hi;
        end
        return val;
    endfunction

endpackage

// File: rtl/wbuf_line_ram.sv
// One image line of storage: DEPTH entries of ITEM_SIZE bits.
// Combinational read and synchronous write at the same address each cycle, so a
// read-modify-write of one column completes in a single clock.
// Contents are not reset.
//   clk   : clock
//   we    : write enable
//   addr  : column address (shared by read and write)
//   wdata : item written at addr on the rising edge when we=1
//   rdata : item currently stored at addr
module wbuf_line_ram #(
    parameter int unsigned ITEM_SIZE = 8,
    parameter int unsigned DEPTH     = 640
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [ITEM_SIZE-1:0]     wdata,
    output logic [ITEM_SIZE-1:0]     rdata
);

    logic [ITEM_SIZE-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/stream_window_buffer.sv
// KxK sliding-window line buffer for raster-order pixel streams.
// Emits only fully interior windows, one per accepted pixel with row>=K-1 and col>=K-1,
// through a single output register with ready/valid on both sides.
// Optional feature: define WBUF_POS_EN to add win_row/win_col (window centre coordinates).
//   clk, rst        : clock, asynchronous active-high reset
//   cfg_width/height: frame size, latched on the first pixel of a frame, clamped to [K, MAX]
//   pixel_in(_valid): input stream, in_ready = !window_valid || out_ready
//   window_out      : window[(r*K+c)*ITEM_SIZE +: ITEM_SIZE], r=0/c=0 oldest
//   window_valid    : output valid, out_ready: downstream ready
//   frame_done      : 1-cycle pulse alongside the final window of a frame
//   win_row/win_col : (WBUF_POS_EN only) centre coordinates of window_out
module stream_window_buffer
    import definitions_pkg::*;
#(
    parameter int unsigned ITEM_SIZE  = 8,
    parameter int unsigned K          = 3,
    parameter int unsigned MAX_WIDTH  = WBUF_DEF_WIDTH,
    parameter int unsigned MAX_HEIGHT = WBUF_DEF_HEIGHT
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [$clog2(MAX_WIDTH+1)-1:0]  cfg_width,
    input  logic [$clog2(MAX_HEIGHT+1)-1:0] cfg_height,
    input  logic [ITEM_SIZE-1:0]            pixel_in,
    input  logic                            pixel_in_valid,
    output logic                            in_ready,
    output logic [K*K*ITEM_SIZE-1:0]        window_out,
    output logic                            window_valid,
    input  logic                            out_ready,
    output logic                            frame_done
`ifdef WBUF_POS_EN
    ,
    output logic [$clog2(MAX_HEIGHT)-1:0]   win_row,
    output logic [$clog2(MAX_WIDTH)-1:0]    win_col
`endif
);

    localparam int unsigned CW  = $clog2(MAX_WIDTH);
    localparam int unsigned RW  = $clog2(MAX_HEIGHT);
    localparam int unsigned WIN = K * K * ITEM_SIZE;

    wbuf_state_t          state_q;
    logic [CW-1:0]        col_q, wmax_q, wmax_cfg, wmax_cur;
    logic [RW-1:0]        row_q, hmax_q, hmax_cfg, hmax_cur;
    logic [ITEM_SIZE-1:0] win_q [K][K];
    logic [ITEM_SIZE-1:0] win_d [K][K];
    logic [ITEM_SIZE-1:0] ram_rd [K-1];
    logic [ITEM_SIZE-1:0] col_vec [K];
    logic [WIN-1:0]       win_flat;
    logic                 accept, frame_start, col_last, row_last, emit;

    assign in_ready    = !window_valid || out_ready;
    assign accept      = pixel_in_valid && in_ready;
    assign frame_start = (row_q == '0) && (col_q == '0);

    // Limits are stored as (size - 1) so they compare directly against the counters.
    assign wmax_cfg = CW'(wbuf_clamp(32'(cfg_width), K, MAX_WIDTH) - 1);
    assign hmax_cfg = RW'(wbuf_clamp(32'(cfg_height), K, MAX_HEIGHT) - 1);
    // The latched limits are stale until the first pixel of the frame is taken.
    assign wmax_cur = frame_start ? wmax_cfg : wmax_q;
    assign hmax_cur = frame_start ? hmax_cfg : hmax_q;
    assign col_last = (col_q == wmax_cur);
    assign row_last = (row_q == hmax_cur);
    assign emit     = accept && (state_q == STREAM) && (col_q >= CW'(K - 1));

    // Column entering the window: K-1 stored lines (oldest first) topped by the new pixel.
    always_comb begin
        for (int r = 0; r < K - 1; r++) begin
            col_vec[r] = ram_rd[r];
        end
        col_vec[K-1] = pixel_in;
    end

    // Each line shifts up by one, so line i is rewritten with what line i+1 held.
    for (genvar i = 0; i < K - 1; i++) begin : g_line
        wbuf_line_ram #(
            .ITEM_SIZE(ITEM_SIZE),
            .DEPTH    (MAX_WIDTH)
        ) u_line (
            .clk  (clk),
            .we   (accept),
            .addr (col_q),
            .wdata(col_vec[i+1]),
            .rdata(ram_rd[i])
        );
    end

    // Shift the window left; clearing at col 0 keeps the previous row's tail out.
    always_comb begin
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) begin
                win_d[r][c] = (col_q == '0) ? '0 : win_q[r][c+1];
            end
            win_d[r][K-1] = col_vec[r];
        end
    end

    always_comb begin
        win_flat = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                win_flat[(r*K+c)*ITEM_SIZE +: ITEM_SIZE] = win_d[r][c];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= FILL;
            col_q        <= '0;
            row_q        <= '0;
            wmax_q       <= '0;
            hmax_q       <= '0;
            win_q        <= '{default: '0};
            window_out   <= '0;
            window_valid <= 1'b0;
            frame_done   <= 1'b0;
`ifdef WBUF_POS_EN
            win_row      <= '0;
            win_col      <= '0;
`endif
        end else begin
            frame_done <= accept && col_last && row_last;
            if (accept) begin
                win_q <= win_d;
                if (frame_start) begin
                    wmax_q <= wmax_cfg;
                    hmax_q <= hmax_cfg;
                end
                if (col_last) begin
                    col_q <= '0;
                    row_q <= row_last ? '0 : row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
                unique case (state_q)
                    FILL: begin
                        if (col_last && (row_q == RW'(K - 2))) begin
                            state_q <= STREAM;
                        end
                    end
                    STREAM: begin
                        if (col_last && row_last) begin
                            state_q <= FILL;
                        end
                    end
                    default: state_q <= FILL;
                endcase
            end
            if (emit) begin
                window_out   <= win_flat;
                window_valid <= 1'b1;
`ifdef WBUF_POS_EN
                win_row      <= row_q - RW'(K / 2);
                win_col      <= col_q - CW'(K / 2);
`endif
            end else if (out_ready) begin
                window_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_window_buffer.sv
// Directed bench for stream_window_buffer: K=3 instance on 640x480 limits for
// streaming, backpressure, input gaps, config change and mid-frame reset, plus a
// K=5 instance on a 16x16 limit for the width clamp.
module tb_stream_window_buffer;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    // K=3 instance
    logic [9:0]  cfg_width;
    logic [8:0]  cfg_height;
    logic [7:0]  pixel_in;
    logic        pixel_in_valid, in_ready, window_valid, out_ready, frame_done;
    logic [71:0] window_out;
`ifdef WBUF_POS_EN
    logic [8:0]  win_row;
    logic [9:0]  win_col;
`endif

    // K=5 instance
    logic [4:0]   cfg_width5, cfg_height5;
    logic [7:0]   pixel_in5;
    logic         pixel_in_valid5, in_ready5, window_valid5, out_ready5, frame_done5;
    logic [199:0] window_out5;
`ifdef WBUF_POS_EN
    logic [3:0]   win_row5, win_col5;
`endif

    int n_checks, n_pass;
    int chg_at, chg_w, chg_h;

    stream_window_buffer #(
        .ITEM_SIZE (8),
        .K         (3),
        .MAX_WIDTH (640),
        .MAX_HEIGHT(480)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_width     (cfg_width),
        .cfg_height    (cfg_height),
        .pixel_in      (pixel_in),
        .pixel_in_valid(pixel_in_valid),
        .in_ready      (in_ready),
        .window_out    (window_out),
        .window_valid  (window_valid),
        .out_ready     (out_ready),
        .frame_done    (frame_done)
`ifdef WBUF_POS_EN
        ,
        .win_row       (win_row),
        .win_col       (win_col)
`endif
    );

    stream_window_buffer #(
        .ITEM_SIZE (8),
        .K         (5),
        .MAX_WIDTH (16),
        .MAX_HEIGHT(16)
    ) dut5 (
        .clk           (clk),
        .rst           (rst),
        .cfg_width     (cfg_width5),
        .cfg_height    (cfg_height5),
        .pixel_in      (pixel_in5),
        .pixel_in_valid(pixel_in_valid5),
        .in_ready      (in_ready5),
        .window_out    (window_out5),
        .window_valid  (window_valid5),
        .out_ready     (out_ready5),
        .frame_done    (frame_done5)
`ifdef WBUF_POS_EN
        ,
        .win_row       (win_row5),
        .win_col       (win_col5)
`endif
    );

    task automatic check(input string tag, input logic [199:0] obs, input logic [199:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pixel at (r,c) is r*16+c; window (r,c) element sits at bits (r*K+c)*8.
    function automatic logic [71:0] exp_win(input int tr, input int tc);
        logic [71:0] v;
        v = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                v[(r*3+c)*8 +: 8] = 8'((tr + r) * 16 + tc + c);
            end
        end
        return v;
    endfunction

    function automatic logic [199:0] exp_win5(input int tr, input int tc);
        logic [199:0] v;
        v = '0;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                v[(r*5+c)*8 +: 8] = 8'((tr + r) * 16 + tc + c);
            end
        end
        return v;
    endfunction

    // Streams npix pixels of a w x h frame into the K=3 instance and checks every
    // consumed window in order, stall stability and the frame_done pulse.
    task automatic run_frame(input int w, input int h, input int npix, input bit tog,
                             input bit gaps);
        int pr, pc, acc, nwin, dones, cyc, post, er, ec, exp_n;
        bit stalled;
        logic [71:0] held;
        pr = 0; pc = 0; acc = 0; nwin = 0; dones = 0; cyc = 0; post = 0; er = 0; ec = 0;
        stalled = 1'b0;
        held = '0;
        exp_n = (npix == w * h) ? (w - 2) * (h - 2) : 0;
        while (post < 4 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            out_ready      = tog ? (cyc % 2 == 0) : 1'b1;
            pixel_in_valid = (acc < npix) && (!gaps || $urandom_range(0, 1) == 1);
            pixel_in       = 8'(pr * 16 + pc);
            if (acc == chg_at) begin
                cfg_width  = 10'(chg_w);
                cfg_height = 9'(chg_h);
            end
            #1;
            if (stalled) check("stall_hold", window_out, held);
            if (window_valid && !out_ready) check("stall_ready", in_ready, 1'b0);
            if (frame_done) begin
                dones++;
                check("done_with_last", {window_valid, 32'(nwin)}, {1'b1, 32'(exp_n - 1)});
            end
            if (window_valid && out_ready) begin
                check("window", window_out, exp_win(er, ec));
`ifdef WBUF_POS_EN
                check("win_row", win_row, 9'(er + 1));
                check("win_col", win_col, 10'(ec + 1));
`endif
                nwin++;
                if (ec == w - 3) begin
                    ec = 0;
                    er++;
                end else begin
                    ec++;
                end
            end
            stalled = window_valid && !out_ready;
            held    = window_out;
            if (pixel_in_valid && in_ready) begin
                acc++;
                if (pc == w - 1) begin
                    pc = 0;
                    pr++;
                end else begin
                    pc++;
                end
            end
            if (acc == npix && nwin >= exp_n) post++;
        end
        check("timeout", cyc < 1000, 1'b1);
        check("win_count", 32'(nwin), 32'(exp_n));
        check("done_count", 32'(dones), (exp_n > 0) ? 32'd1 : 32'd0);
    endtask

    // K=5 with cfg_width=2: clamped to 5, a 5x5 frame yields one window.
    task automatic run_k5();
        int pr, pc, acc, nwin, dones;
        pr = 0; pc = 0; acc = 0; nwin = 0; dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            pixel_in_valid5 = (acc < 25);
            pixel_in5       = 8'(pr * 16 + pc);
            #1;
            if (window_valid5) begin
                check("k5_window", window_out5, exp_win5(0, 0));
`ifdef WBUF_POS_EN
                check("k5_win_row", win_row5, 4'd2);
                check("k5_win_col", win_col5, 4'd2);
`endif
                nwin++;
            end
            if (frame_done5) dones++;
            if (pixel_in_valid5 && in_ready5) begin
                acc++;
                if (pc == 4) begin
                    pc = 0;
                    pr++;
                end else begin
                    pc++;
                end
            end
        end
        pixel_in_valid5 = 1'b0;
        check("k5_accepted", 32'(acc), 32'd25);
        check("k5_win_count", 32'(nwin), 32'd1);
        check("k5_done_count", 32'(dones), 32'd1);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        chg_at   = -1;
        chg_w    = 0;
        chg_h    = 0;
        rst             = 1'b1;
        cfg_width       = 10'd5;
        cfg_height      = 9'd4;
        pixel_in        = '0;
        pixel_in_valid  = 1'b0;
        out_ready       = 1'b1;
        cfg_width5      = 5'd2;
        cfg_height5     = 5'd5;
        pixel_in5       = '0;
        pixel_in_valid5 = 1'b0;
        out_ready5      = 1'b1;

        repeat (2) @(negedge clk);
        check("reset_valid", window_valid, 1'b0);
        check("reset_done", frame_done, 1'b0);
        check("reset_window", window_out, 72'd0);
        check("reset_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;

        // Free-flowing 5x4 frame.
        run_frame(5, 4, 20, 1'b0, 1'b0);
        // Downstream ready toggling every cycle.
        run_frame(5, 4, 20, 1'b1, 1'b0);
        // Random input gaps.
        run_frame(5, 4, 20, 1'b0, 1'b1);
        // Config changed mid-frame takes effect only on the next frame.
        chg_at = 5;
        chg_w  = 8;
        chg_h  = 3;
        run_frame(5, 4, 20, 1'b0, 1'b0);
        chg_at = -1;
        run_frame(8, 3, 24, 1'b0, 1'b0);

        // Reset after 9 pixels, then a whole frame.
        cfg_width  = 10'd5;
        cfg_height = 9'd4;
        run_frame(5, 4, 9, 1'b0, 1'b0);
        @(negedge clk);
        rst            = 1'b1;
        pixel_in_valid = 1'b0;
        #1;
        check("midrst_valid", window_valid, 1'b0);
        check("midrst_done", frame_done, 1'b0);
        @(negedge clk);
        #1;
        check("midrst_valid_hold", window_valid, 1'b0);
        rst = 1'b0;
        run_frame(5, 4, 20, 1'b1, 1'b1);

        // Width clamp on the K=5 instance.
        run_k5();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
